song_dump_tx: RTL and testbench

Reads the recorded note sequence back out of the note BRAM and sends it, byte by byte, over a UART serial line (8N1, LSB first). It is the transmit-side counterpart of the note-recording path, which fills the BRAM from UART_RX. It sits beside the playback FSM in the top level and shares the BRAM read port. The top level arbitrates that port: playback and dump are never active together. The host can then read back exactly what was recorded.

---
 rtl/song_dump_tx.sv | 180 ++++++++++++++++++
 tb/tb_song_dump_tx.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/song_dump_tx.sv
// Streams the recorded note BRAM out over an 8N1 UART line, LSB first,
// optionally followed by a terminator byte.
module song_dump_tx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned SEND_TERM    = 1,
    parameter logic [7:0]  TERM_BYTE    = 8'h0A
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [9:0] addr_max,
    output logic [9:0] mem_addr,
    input  logic [7:0] mem_dout,
    output logic       UART_TX,
    output logic       busy,
    output logic       done
);

    localparam int unsigned BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic        TERM_EN   = (SEND_TERM != 0);

    // NEXT has no cycle of its own: the index step happens on the STOP exit.
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t        state_q, state_d;
    logic          fetch_q, fetch_d;
    logic [BW-1:0] baud_q,  baud_d;
    logic [2:0]    bit_q,   bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [10:0]   idx_q,   idx_d;
    logic [9:0]    lim_q,   lim_d;
    logic [9:0]    addr_q,  addr_d;
    logic          tx_q,    tx_d;
    logic          busy_q,  busy_d;
    logic          done_q,  done_d;

    logic [10:0] last_idx;
    logic [10:0] idx_inc;
    logic [9:0]  next_addr;
    logic        term_pass;
    logic        baud_end;

    assign last_idx  = {1'b0, lim_q} + 11'(TERM_EN);
    assign idx_inc   = idx_q + 11'd1;
    // Terminator pass keeps the address pinned at lim instead of wrapping.
    assign next_addr = (idx_inc > {1'b0, lim_q}) ? lim_q : idx_inc[9:0];
    assign term_pass = TERM_EN && (idx_q == ({1'b0, lim_q} + 11'd1));
    assign baud_end  = (baud_q == BAUD_LAST);

    always_comb begin
        state_d = state_q;
        fetch_d = fetch_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        lim_d   = lim_q;
        addr_d  = addr_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (start) begin
                    lim_d   = addr_max;
                    idx_d   = '0;
                    addr_d  = '0;
                    fetch_d = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_FETCH;
                end
            end

            S_FETCH: begin
                if (!fetch_q) begin
                    fetch_d = 1'b1;
                end else begin
                    fetch_d = 1'b0;
                    shift_d = term_pass ? TERM_BYTE : mem_dout;
                    baud_d  = '0;
                    tx_d    = 1'b0;
                    state_d = S_START;
                end
            end

            S_START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end

            S_DATA: begin
                if (baud_end) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end

            S_STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (idx_q == last_idx) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        idx_d   = idx_inc;
                        addr_d  = next_addr;
                        fetch_d = 1'b0;
                        state_d = S_FETCH;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            fetch_q <= 1'b0;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            idx_q   <= '0;
            lim_q   <= '0;
            addr_q  <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            fetch_q <= fetch_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            lim_q   <= lim_d;
            addr_q  <= addr_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign mem_addr = addr_q;
    assign UART_TX  = tx_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_song_dump_tx.sv
// Bench for song_dump_tx: two instances (terminator on/off), BRAM models,
// UART decoders feeding a byte scoreboard, plus per-cycle line and timing checks.
module tb_song_dump_tx;

    localparam int C        = 4;
    localparam int BYTE_CYC = 2 + 10 * C;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_t, start_t, tx_t, busy_t, done_t;
    logic [9:0] amax_t, addr_t;
    logic [7:0] dout_t;
    logic       reset_n, start_n, tx_n, busy_n, done_n;
    logic [9:0] amax_n, addr_n;
    logic [7:0] dout_n;

    logic [7:0] mem_t [0:1023];
    logic [7:0] mem_n [0:1023];

    always @(posedge clk) dout_t <= mem_t[addr_t];
    always @(posedge clk) dout_n <= mem_n[addr_n];

    song_dump_tx #(.CLKS_PER_BIT(C), .SEND_TERM(1), .TERM_BYTE(8'h0A)) dut_t (
        .clk(clk), .reset(reset_t), .start(start_t), .addr_max(amax_t),
        .mem_addr(addr_t), .mem_dout(dout_t), .UART_TX(tx_t), .busy(busy_t), .done(done_t)
    );

    song_dump_tx #(.CLKS_PER_BIT(C), .SEND_TERM(0), .TERM_BYTE(8'h0A)) dut_n (
        .clk(clk), .reset(reset_n), .start(start_n), .addr_max(amax_n),
        .mem_addr(addr_n), .mem_dout(dout_n), .UART_TX(tx_n), .busy(busy_n), .done(done_n)
    );

    int checks = 0;
    int errors = 0;
    logic [7:0] q_t [$];
    logic [7:0] q_n [$];
    int rx_t = 0;
    int rx_n = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Entered on the first low sample of a start bit; samples each bit one cycle in.
    task automatic uart_rx(input bit s, output logic [7:0] data, output bit framed, output bit aborted);
        logic [9:0] bits;
        bits    = '0;
        aborted = 1'b0;
        for (int n = 1; n <= 9 * C + 1; n++) begin
            @(negedge clk);
            if (s ? reset_t : reset_n) begin
                aborted = 1'b1;
                framed  = 1'b0;
                data    = '0;
                return;
            end
            if (n % C == 1) bits[n / C] = s ? tx_t : tx_n;
        end
        data   = bits[8:1];
        framed = (bits[0] == 1'b0) && (bits[9] == 1'b1);
    endtask

    initial begin : mon_t
        logic [7:0] d;
        bit ok, ab;
        forever begin
            @(negedge clk);
            if (reset_t === 1'b0 && tx_t === 1'b0) begin
                uart_rx(1'b1, d, ok, ab);
                if (!ab) begin
                    rx_t++;
                    check("t_frame", 32'(ok), 32'd1);
                    if (q_t.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL t_unexpected_byte: got %0h, expected no byte", d);
                    end else check("t_byte", 32'(d), 32'(q_t.pop_front()));
                end
            end
        end
    end

    initial begin : mon_n
        logic [7:0] d;
        bit ok, ab;
        forever begin
            @(negedge clk);
            if (reset_n === 1'b0 && tx_n === 1'b0) begin
                uart_rx(1'b0, d, ok, ab);
                if (!ab) begin
                    rx_n++;
                    check("n_frame", 32'(ok), 32'd1);
                    if (q_n.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL n_unexpected_byte: got %0h, expected no byte", d);
                    end else check("n_byte", 32'(d), 32'(q_n.pop_front()));
                end
            end
        end
    end

    function automatic logic [7:0] mem_rd(input bit s, input int a);
        return s ? mem_t[a] : mem_n[a];
    endfunction

    task automatic set_start(input bit s, input logic v);
        if (s) start_t = v; else start_n = v;
    endtask

    // Returns at the negedge of the first busy cycle; addr_max is scrambled afterwards.
    task automatic pulse_start(input bit s, input logic [9:0] amax);
        @(negedge clk);
        set_start(s, 1'b1);
        if (s) amax_t = amax; else amax_n = amax;
        @(negedge clk);
        set_start(s, 1'b0);
        if (s) amax_t = ~amax; else amax_n = ~amax;
    endtask

    task automatic wait_done(input bit s, input int budget, output int k, output bit seen);
        seen = 1'b0;
        for (k = 1; k <= budget; k++) begin
            @(negedge clk);
            if (s ? done_t : done_n) begin
                seen = 1'b1;
                return;
            end
        end
    endtask

    task automatic run_dump(input bit s, input int amax, input int poke, input int exp_cyc, input int tag);
        logic [7:0] bytes [$];
        logic [7:0] cur;
        logic [9:0] prev, a;
        logic       exp_tx;
        int         k, b, off, bad_tx, first_bad, mono_bad;
        bit         seen;
        string      nm;

        for (int i = 0; i <= amax; i++) bytes.push_back(mem_rd(s, i));
        if (s) bytes.push_back(8'h0A);
        foreach (bytes[i]) begin
            if (s) q_t.push_back(bytes[i]); else q_n.push_back(bytes[i]);
        end

        pulse_start(s, 10'(amax));
        nm = $sformatf("v%0d_busy_rise", tag);
        check(nm, 32'(s ? busy_t : busy_n), 32'd1);
        nm = $sformatf("v%0d_addr_first", tag);
        check(nm, 32'(s ? addr_t : addr_n), 32'd0);

        seen = 1'b0; prev = '0; mono_bad = 0; bad_tx = 0; first_bad = -1;
        for (k = 0; k <= exp_cyc + 200; k++) begin
            if (k > 0) begin
                @(negedge clk);
                set_start(s, k == poke);
            end
            if (s ? done_t : done_n) begin
                seen = 1'b1;
                break;
            end
            b   = k / BYTE_CYC;
            off = k % BYTE_CYC;
            if (b >= bytes.size() || off < 2 || off >= 2 + 9 * C) exp_tx = 1'b1;
            else if (off < 2 + C) exp_tx = 1'b0;
            else begin
                cur    = bytes[b];
                exp_tx = cur[(off - 2 - C) / C];
            end
            if ((s ? tx_t : tx_n) !== exp_tx) begin
                bad_tx++;
                if (first_bad < 0) first_bad = k;
            end
            a = s ? addr_t : addr_n;
            if (a < prev) mono_bad++;
            prev = a;
        end
        set_start(s, 1'b0);

        nm = $sformatf("v%0d_done_seen", tag);     check(nm, 32'(seen), 32'd1);
        nm = $sformatf("v%0d_done_cycle", tag);    check(nm, 32'(k), 32'(exp_cyc));
        nm = $sformatf("v%0d_busy_fall", tag);     check(nm, 32'(s ? busy_t : busy_n), 32'd0);
        nm = $sformatf("v%0d_addr_last", tag);     check(nm, 32'(s ? addr_t : addr_n), 32'(amax));
        nm = $sformatf("v%0d_addr_monotone", tag); check(nm, 32'(mono_bad), 32'd0);
        nm = $sformatf("v%0d_line_trace_first_bad_cycle_%0d", tag, first_bad);
        check(nm, 32'(bad_tx), 32'd0);
        @(negedge clk);
        nm = $sformatf("v%0d_done_pulse", tag);    check(nm, 32'(s ? done_t : done_n), 32'd0);
        repeat (60) @(negedge clk);
        nm = $sformatf("v%0d_no_restart", tag);    check(nm, 32'(s ? busy_t : busy_n), 32'd0);
        nm = $sformatf("v%0d_bytes_left", tag);    check(nm, 32'(s ? q_t.size() : q_n.size()), 32'd0);
    endtask

    typedef struct {
        bit s;
        int amax;
        int poke;
        int exp_cyc;
    } vec_t;

    vec_t vecs [6];

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int  k, rx0;
        bit  seen;

        vecs[0] = '{1'b1, 2,    -1, 168};
        vecs[1] = '{1'b1, 2,    50, 168};
        vecs[2] = '{1'b0, 0,    -1, 42};
        vecs[3] = '{1'b0, 3,    -1, 168};
        vecs[4] = '{1'b1, 0,    -1, 84};
        vecs[5] = '{1'b1, 1023, -1, 43050};

        for (int i = 0; i < 1024; i++) begin
            mem_t[i] = 8'(i * 37 + 5);
            mem_n[i] = 8'(i * 13 + 90);
        end
        mem_t[0] = 8'h41; mem_t[1] = 8'h42; mem_t[2] = 8'h43;
        mem_n[0] = 8'hA5;

        reset_t = 1'b0; reset_n = 1'b0;
        start_t = 1'b0; start_n = 1'b0;
        amax_t  = '0;   amax_n  = '0;

        #2;
        reset_t = 1'b1; reset_n = 1'b1;
        #1;
        check("rst_tx",   32'(tx_t),   32'd1);
        check("rst_busy", 32'(busy_t), 32'd0);
        check("rst_done", 32'(done_t), 32'd0);
        check("rst_addr", 32'(addr_t), 32'd0);
        check("rst_tx_n", 32'(tx_n),   32'd1);
        repeat (3) @(negedge clk);
        reset_t = 1'b0; reset_n = 1'b0;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 6; i++) run_dump(vecs[i].s, vecs[i].amax, vecs[i].poke, vecs[i].exp_cyc, i);

        // Reset during bit 3 of the second byte, then a fresh dump from address 0.
        for (int i = 0; i <= 2; i++) q_t.push_back(mem_t[i]);
        q_t.push_back(8'h0A);
        rx0 = rx_t;
        pulse_start(1'b1, 10'd2);
        repeat (61) @(negedge clk);
        #1 reset_t = 1'b1;
        #1;
        check("midrst_tx",   32'(tx_t),   32'd1);
        check("midrst_busy", 32'(busy_t), 32'd0);
        check("midrst_done", 32'(done_t), 32'd0);
        check("midrst_addr", 32'(addr_t), 32'd0);
        repeat (6) @(negedge clk);
        reset_t = 1'b0;
        q_t.delete();
        check("midrst_bytes_before", 32'(rx_t - rx0), 32'd1);
        repeat (3) @(negedge clk);
        run_dump(1'b1, 2, -1, 168, 10);

        // A start presented during the done cycle begins the next dump.
        q_n.push_back(mem_n[0]);
        pulse_start(1'b0, 10'd0);
        wait_done(1'b0, 200, k, seen);
        check("chain_first_seen", 32'(seen), 32'd1);
        check("chain_first_done", 32'(k), 32'd42);
        start_n = 1'b1; amax_n = 10'd0;
        q_n.push_back(mem_n[0]);
        @(negedge clk);
        start_n = 1'b0; amax_n = 10'h3FF;
        check("chain_accept_busy", 32'(busy_n), 32'd1);
        check("chain_accept_addr", 32'(addr_n), 32'd0);
        wait_done(1'b0, 200, k, seen);
        check("chain_second_seen", 32'(seen), 32'd1);
        check("chain_second_done", 32'(k), 32'd42);
        repeat (60) @(negedge clk);
        check("chain_bytes_left", 32'(q_n.size()), 32'd0);
        check("chain_idle", 32'(busy_n), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
